// File: rtl/decode_stage_if.sv
// IF/ID -> ID/EX bundle for the decode stage: fetch-side inputs,
// writeback port and the registered ID/EX outputs.
interface decode_stage_if;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    logic        branch_cond;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hazard;
    logic        id_ex_valid;
    logic [31:0] id_ex_ir;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_a;
    logic [31:0] id_ex_b;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rd;
    logic        id_ex_is_load;
    logic [15:0] stall_count;

    modport master (
        output if_id_ir, if_id_npc, branch_cond,
        output wb_en, wb_rd, wb_data,
        input  hazard, id_ex_valid, id_ex_ir, id_ex_npc,
        input  id_ex_a, id_ex_b, id_ex_imm, id_ex_rd,
        input  id_ex_is_load, stall_count
    );

    modport slave (
        input  if_id_ir, if_id_npc, branch_cond,
        input  wb_en, wb_rd, wb_data,
        output hazard, id_ex_valid, id_ex_ir, id_ex_npc,
        output id_ex_a, id_ex_b, id_ex_imm, id_ex_rd,
        output id_ex_is_load, stall_count
    );
endinterface

// File: rtl/decode_stage.sv
// ID stage: register file, immediates, load-use stall FSM, branch squash.
// Optional hazard-cycle counter enabled by DECODE_STALL_STATS_EN.
module decode_stage #(
    parameter int unsigned LOAD_USE_STALLS = 1
) (
    input logic clk,
    input logic reset,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALLS - 1);

    typedef enum logic {RUN, STALL} state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        is_load;
    } id_ex_t;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    id_ex_t      id_ex_q, id_ex_d, dec;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd_f;
    logic        is_i, is_s, is_b, is_u, is_j;
    logic        uses_rs1, uses_rs2, has_rd;
    logic        ld_use, hazard_c, bubble;
    logic [31:0] imm, rs1_val, rs2_val;

    assign ir     = bus.if_id_ir;
    assign opcode = ir[6:0];
    assign rd_f   = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    assign is_i = opcode == OP_LOAD || opcode == OP_IMM
               || opcode == OP_JALR;
    assign is_s = opcode == OP_STORE;
    assign is_b = opcode == OP_BRANCH;
    assign is_u = opcode == OP_LUI || opcode == OP_AUIPC;
    assign is_j = opcode == OP_JAL;

    assign uses_rs1 = !(is_u || is_j);
    assign uses_rs2 = opcode == OP_REG || is_s || is_b;
    assign has_rd   = !(is_s || is_b);

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_i: imm = {{20{ir[31]}}, ir[31:20]};
            is_s: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            is_b: imm = {{19{ir[31]}}, ir[31], ir[7],
                         ir[30:25], ir[11:8], 1'b0};
            is_u: imm = {ir[31:12], 12'b0};
            is_j: imm = {{11{ir[31]}}, ir[31], ir[19:12],
                         ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // A writeback landing this cycle is visible to the read ports.
    always_comb begin
        rs1_val = rf_q[rs1];
        if (rs1 == 5'd0)
            rs1_val = '0;
        else if (bus.wb_en && bus.wb_rd == rs1)
            rs1_val = bus.wb_data;
    end

    always_comb begin
        rs2_val = rf_q[rs2];
        if (rs2 == 5'd0)
            rs2_val = '0;
        else if (bus.wb_en && bus.wb_rd == rs2)
            rs2_val = bus.wb_data;
    end

    always_comb begin
        rf_d = rf_q;
        if (bus.wb_en && bus.wb_rd != 5'd0)
            rf_d[bus.wb_rd] = bus.wb_data;
    end

    always_comb begin
        dec         = '0;
        dec.valid   = ir != 32'h0;
        dec.ir      = ir;
        dec.npc     = bus.if_id_npc;
        dec.a       = rs1_val;
        dec.b       = rs2_val;
        dec.imm     = imm;
        dec.rd      = has_rd ? rd_f : 5'd0;
        dec.is_load = opcode == OP_LOAD;
    end

    assign ld_use = id_ex_q.valid && id_ex_q.is_load
                 && id_ex_q.rd != 5'd0
                 && ((uses_rs1 && rs1 == id_ex_q.rd)
                  || (uses_rs2 && rs2 == id_ex_q.rd))
                 && ir != 32'h0;

    // A taken branch outranks any stall: the if_id word is wrong-path.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hazard_c = 1'b0;
        bubble   = 1'b0;
        if (bus.branch_cond) begin
            bubble  = 1'b1;
            state_d = RUN;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ld_use) begin
                        hazard_c = 1'b1;
                        bubble   = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_d = STALL;
                            cnt_d   = STALL_INIT;
                        end
                    end
                end
                STALL: begin
                    hazard_c = 1'b1;
                    bubble   = 1'b1;
                    cnt_d    = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign id_ex_d = bubble ? '0 : dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            id_ex_q <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_ex_q <= id_ex_d;
            rf_q    <= rf_d;
        end
    end

    assign bus.hazard        = hazard_c && !reset;
    assign bus.id_ex_valid   = id_ex_q.valid;
    assign bus.id_ex_ir      = id_ex_q.ir;
    assign bus.id_ex_npc     = id_ex_q.npc;
    assign bus.id_ex_a       = id_ex_q.a;
    assign bus.id_ex_b       = id_ex_q.b;
    assign bus.id_ex_imm     = id_ex_q.imm;
    assign bus.id_ex_rd      = id_ex_q.rd;
    assign bus.id_ex_is_load = id_ex_q.is_load;

`ifdef DECODE_STALL_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_c && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.stall_count = 16'h0;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances (1 and 3 load-use
// stalls), expected ID/EX contents queued per instance at drive time.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    decode_stage_if b1 ();
    decode_stage_if b3 ();

    decode_stage #(.LOAD_USE_STALLS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    decode_stage #(.LOAD_USE_STALLS(3)) dut3 (
        .clk(clk), .reset(reset), .bus(b3)
    );

    typedef struct {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        is_load;
    } exp_t;

    localparam logic [31:0] ADD_1_5_0 = 32'h000280B3;
    localparam logic [31:0] ADD_6_5_5 = 32'h00528333;
    localparam logic [31:0] ADD_1_0_0 = 32'h000000B3;
    localparam logic [31:0] LW_X0     = 32'h00002003;
    localparam logic [31:0] ADDI_M1   = 32'hFFF00093;
    localparam logic [31:0] LUI_X2    = 32'h12345137;
    localparam logic [31:0] BEQ_M8    = 32'hFE000CE3;
    localparam logic [31:0] LW_3_2    = 32'h00012183;
    localparam logic [31:0] ADD_4_3_3 = 32'h00318233;

`ifdef DECODE_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    exp_t q1[$];
    exp_t q3[$];
    int checks = 0;
    int errors = 0;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] ir,
        input logic [31:0] npc, input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] imm,
        input logic [4:0] rd, input logic ld);
        exp_t e;
        e = '{v, ir, npc, a, b, imm, rd, ld};
        return e;
    endfunction

    function automatic exp_t bub();
        return mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endfunction

    function automatic exp_t get_obs(input bit sel3);
        exp_t o;
        if (sel3)
            o = '{b3.id_ex_valid, b3.id_ex_ir, b3.id_ex_npc, b3.id_ex_a,
                  b3.id_ex_b, b3.id_ex_imm, b3.id_ex_rd, b3.id_ex_is_load};
        else
            o = '{b1.id_ex_valid, b1.id_ex_ir, b1.id_ex_npc, b1.id_ex_a,
                  b1.id_ex_b, b1.id_ex_imm, b1.id_ex_rd, b1.id_ex_is_load};
        return o;
    endfunction

    task automatic cmp_ex(input string t, input exp_t o, input exp_t e);
        chk({t, ".valid"}, 32'(o.valid), 32'(e.valid));
        chk({t, ".ir"}, o.ir, e.ir);
        chk({t, ".npc"}, o.npc, e.npc);
        chk({t, ".a"}, o.a, e.a);
        chk({t, ".b"}, o.b, e.b);
        chk({t, ".imm"}, o.imm, e.imm);
        chk({t, ".rd"}, 32'(o.rd), 32'(e.rd));
        chk({t, ".is_load"}, 32'(o.is_load), 32'(e.is_load));
    endtask

    task automatic idle(input bit sel3);
        if (sel3) begin
            b3.if_id_ir = '0; b3.if_id_npc = '0; b3.branch_cond = 1'b0;
            b3.wb_en = 1'b0; b3.wb_rd = '0; b3.wb_data = '0;
        end else begin
            b1.if_id_ir = '0; b1.if_id_npc = '0; b1.branch_cond = 1'b0;
            b1.wb_en = 1'b0; b1.wb_rd = '0; b1.wb_data = '0;
        end
    endtask

    task automatic step(input bit sel3, input logic [31:0] ir,
                        input logic [31:0] npc, input logic br,
                        input logic exp_haz, input exp_t e,
                        input string tag);
        exp_t ex1, ex3;
        idle(!sel3);
        if (sel3) begin
            b3.if_id_ir = ir; b3.if_id_npc = npc; b3.branch_cond = br;
            b3.wb_en = wen; b3.wb_rd = wrd; b3.wb_data = wdat;
        end else begin
            b1.if_id_ir = ir; b1.if_id_npc = npc; b1.branch_cond = br;
            b1.wb_en = wen; b1.wb_rd = wrd; b1.wb_data = wdat;
        end
        q1.push_back((!sel3 && !exp_haz && !br) ? e : bub());
        q3.push_back((sel3 && !exp_haz && !br) ? e : bub());
        @(negedge clk);
        chk({tag, "/d1.hazard"}, 32'(b1.hazard),
            32'(!sel3 && exp_haz));
        chk({tag, "/d3.hazard"}, 32'(b3.hazard),
            32'(sel3 && exp_haz));
        @(posedge clk);
        #1;
        ex1 = q1.pop_front();
        ex3 = q3.pop_front();
        cmp_ex({tag, "/d1"}, get_obs(1'b0), ex1);
        cmp_ex({tag, "/d3"}, get_obs(1'b1), ex3);
        wen = 1'b0; wrd = '0; wdat = '0;
    endtask

    task automatic do_reset(input logic [31:0] ir3);
        reset = 1'b1;
        idle(1'b0);
        idle(1'b1);
        b3.if_id_ir = ir3;
        @(negedge clk);
        chk("rst/d1.hazard", 32'(b1.hazard), 32'h0);
        chk("rst/d3.hazard", 32'(b3.hazard), 32'h0);
        @(posedge clk);
        #1;
        cmp_ex("rst/d1", get_obs(1'b0), bub());
        cmp_ex("rst/d3", get_obs(1'b1), bub());
        chk("rst/d1.stall_count", 32'(b1.stall_count), 32'h0);
        chk("rst/d3.stall_count", 32'(b3.stall_count), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        wen = 1'b0; wrd = '0; wdat = '0;
        do_reset(32'h0);

        wen = 1'b1; wrd = 5'd5; wdat = 32'hDEAD_BEEF;
        step(0, ADD_1_5_0, 32'h104, 0, 0, mk(1, ADD_1_5_0, 32'h104,
             32'hDEAD_BEEF, 0, 0, 5'd1, 0), "bypass");
        step(0, ADD_6_5_5, 32'h108, 0, 0, mk(1, ADD_6_5_5, 32'h108,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 5'd6, 0), "rf_read");

        wen = 1'b1; wrd = 5'd0; wdat = 32'h7;
        step(0, ADD_1_0_0, 32'h10C, 0, 0, mk(1, ADD_1_0_0, 32'h10C,
             0, 0, 0, 5'd1, 0), "x0_bypass");
        step(0, ADD_1_0_0, 32'h110, 0, 0, mk(1, ADD_1_0_0, 32'h110,
             0, 0, 0, 5'd1, 0), "x0_read");
        step(0, LW_X0, 32'h114, 0, 0, mk(1, LW_X0, 32'h114,
             0, 0, 0, 5'd0, 1), "lw_x0");
        step(0, ADD_1_0_0, 32'h118, 0, 0, mk(1, ADD_1_0_0, 32'h118,
             0, 0, 0, 5'd1, 0), "x0_use");

        step(0, ADDI_M1, 32'h11C, 0, 0, mk(1, ADDI_M1, 32'h11C,
             0, 0, 32'hFFFF_FFFF, 5'd1, 0), "imm_i");
        step(0, LUI_X2, 32'h120, 0, 0, mk(1, LUI_X2, 32'h120,
             0, 0, 32'h1234_5000, 5'd2, 0), "imm_u");
        step(0, BEQ_M8, 32'h124, 0, 0, mk(1, BEQ_M8, 32'h124,
             0, 0, 32'hFFFF_FFF8, 5'd0, 0), "imm_b");

        wen = 1'b1; wrd = 5'd2; wdat = 32'h1000;
        step(0, 32'h0, 32'h0, 0, 0, bub(), "wr_x2_d1");
        step(0, LW_3_2, 32'h130, 0, 0, mk(1, LW_3_2, 32'h130,
             32'h1000, 0, 0, 5'd3, 1), "lu1_lw");
        wen = 1'b1; wrd = 5'd3; wdat = 32'h55;
        step(0, ADD_4_3_3, 32'h134, 0, 1, bub(), "lu1_stall");
        step(0, ADD_4_3_3, 32'h134, 0, 0, mk(1, ADD_4_3_3, 32'h134,
             32'h55, 32'h55, 0, 5'd4, 0), "lu1_issue");

        wen = 1'b1; wrd = 5'd2; wdat = 32'h2000;
        step(1, 32'h0, 32'h0, 0, 0, bub(), "wr_x2_d3");
        step(1, LW_3_2, 32'h200, 0, 0, mk(1, LW_3_2, 32'h200,
             32'h2000, 0, 0, 5'd3, 1), "lu3_lw");
        step(1, ADD_4_3_3, 32'h204, 0, 1, bub(), "lu3_s1");
        step(1, ADD_4_3_3, 32'h204, 0, 1, bub(), "lu3_s2");
        step(1, ADD_4_3_3, 32'h204, 0, 1, bub(), "lu3_s3");
        step(1, ADD_4_3_3, 32'h204, 0, 0, mk(1, ADD_4_3_3, 32'h204,
             0, 0, 0, 5'd4, 0), "lu3_issue");
        chk("stats/d1", 32'(b1.stall_count), STATS ? 32'd1 : 32'd0);
        chk("stats/d3", 32'(b3.stall_count), STATS ? 32'd3 : 32'd0);

        step(1, LW_3_2, 32'h208, 0, 0, mk(1, LW_3_2, 32'h208,
             32'h2000, 0, 0, 5'd3, 1), "br_lw");
        step(1, ADD_4_3_3, 32'h20C, 0, 1, bub(), "br_s1");
        step(1, ADD_4_3_3, 32'h20C, 1, 0, bub(), "br_squash");
        step(1, ADDI_M1, 32'h210, 0, 0, mk(1, ADDI_M1, 32'h210,
             0, 0, 32'hFFFF_FFFF, 5'd1, 0), "br_after");
        chk("stats_br/d3", 32'(b3.stall_count), STATS ? 32'd4 : 32'd0);

        step(1, LW_3_2, 32'h214, 0, 0, mk(1, LW_3_2, 32'h214,
             32'h2000, 0, 0, 5'd3, 1), "rs_lw");
        step(1, ADD_4_3_3, 32'h218, 0, 1, bub(), "rs_s1");
        do_reset(ADD_4_3_3);
        step(1, ADD_4_3_3, 32'h218, 0, 0, mk(1, ADD_4_3_3, 32'h218,
             0, 0, 0, 5'd4, 0), "rs_after");
        step(0, ADD_6_5_5, 32'h21C, 0, 0, mk(1, ADD_6_5_5, 32'h21C,
             0, 0, 0, 5'd6, 0), "rf_cleared");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage 2 (ID). Consumes the IF/ID bundle (instruction word plus npc) and drives the ID/EX register.
- Returns `hazard` to the fetch stage, which holds pc/npc while it is high.
- Contains the 32x32 register file with its writeback port, immediate generation, load-use hazard detection with a configurable stall depth, and squash on a taken branch from EX/MEM.

Parameters:
LOAD_USE_STALLS, 1, number of bubble cycles inserted per load-use hazard (legal range 1..7)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_id_ir  input  32  instruction from fetch; 32'h0 means bubble
if_id_npc  input  32  pc tag from fetch; forwarded unchanged
branch_cond  input  1  EX/MEM.cond: taken branch this cycle
wb_en  input  1  writeback enable
wb_rd  input  5  writeback destination register
wb_data  input  32  writeback data
hazard  output  1  combinational; fetch must recirculate the current instruction
id_ex_valid  output  1  ID/EX holds a real instruction
id_ex_ir  output  32  instruction
id_ex_npc  output  32  npc
id_ex_a  output  32  rs1 value
id_ex_b  output  32  rs2 value
id_ex_imm  output  32  sign-extended immediate
id_ex_rd  output  5  destination register (0 if none)
id_ex_is_load  output  1  opcode is 7'b0000011
stall_count  output  16  hazard cycle counter (see optional feature)

Behaviour:
- Decode fields:
  - opcode = ir[6:0], rd = ir[11:7], rs1 = ir[19:15], rs2 = ir[24:20].
  - Uses rs1: all opcodes except U (0110111, 0010111) and JAL (1101111).
  - Uses rs2: R (0110011), S (0100011), B (1100011).
  - Has rd: all except S, B.
- Immediate:
  - I (0000011, 0010011, 1100111): sext ir[31:20].
  - S: sext {ir[31:25], ir[11:7]}.
  - B: sext {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}.
  - U: {ir[31:12], 12'b0}.
  - J: sext {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}.
  - Others: 0.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write occurs on posedge when wb_en is high.
  - Same-cycle read bypass: if wb_en && wb_rd == rs && rs != 0, the read returns wb_data.
- Load-use condition (ld_use) = id_ex_valid && id_ex_is_load && id_ex_rd != 0 && ((uses rs1 && rs1 == id_ex_rd) || (uses rs2 && rs2 == id_ex_rd)) && if_id_ir != 0.
- FSM states: RUN, STALL. 3-bit counter cnt.
  - RUN, ld_use && !branch_cond:
    - hazard = 1; ID/EX loads a bubble.
    - If LOAD_USE_STALLS > 1: go to STALL with cnt = LOAD_USE_STALLS - 1.
  - RUN, otherwise: hazard = 0; ID/EX loads the decoded instruction (valid = 0 if if_id_ir == 0).
  - STALL: hazard = 1; bubble into ID/EX; cnt decrements; return to RUN on the edge where cnt == 1.
  - branch_cond, any state (priority over hazard):
    - hazard = 0; ID/EX loads a bubble (squashes the wrong-path if_id); next state RUN; cnt = 0.
- Bubble contents: valid = 0, ir = 0, rd = 0, is_load = 0. a, b, imm and npc are don't-care but are driven 0.
- Latency: an instruction presented on if_id with hazard = 0 appears on id_ex one cycle later.
- Reset:
  - All ID/EX outputs 0; register file cleared to 0; state RUN; cnt 0; stall_count 0.
  - hazard is forced 0 while reset is high.
  - Reset mid-STALL aborts the stall.
- Simultaneous events:
  - Writeback to the register being read: bypass applies.
  - Writeback during a stall still updates the register file.
  - branch_cond during STALL terminates the stall immediately.

Optional Feature:
- Macro: DECODE_STALL_STATS_EN.
- Defined:
  - stall_count increments on every cycle with hazard == 1.
  - Saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined: stall_count is tied to 16'h0 and no counter flop exists.

Test Plan:
- Reset, then wb_en=1 wb_rd=5 wb_data=32'hDEAD_BEEF; same cycle if_id_ir = add x1,x5,x0 -> next cycle id_ex_a=32'hDEADBEEF, id_ex_b=0, id_ex_rd=1, id_ex_valid=1.
- Load-use, LOAD_USE_STALLS=1: lw x3,0(x2) then add x4,x3,x3 -> hazard=1 for exactly 1 cycle, one bubble (id_ex_valid=0), then add issues with id_ex_rd=4.
- Load-use, LOAD_USE_STALLS=3: same sequence -> hazard high 3 consecutive cycles, 3 bubbles; with DECODE_STALL_STATS_EN, stall_count=3.
- branch_cond=1 on the second stall cycle (LOAD_USE_STALLS=3) -> hazard=0 that cycle, id_ex bubble next edge, state RUN; the following if_id issues normally.
- Immediates: addi x1,x0,-1 -> id_ex_imm=32'hFFFF_FFFF; lui x2,0x12345 -> id_ex_imm=32'h1234_5000; beq x0,x0,-8 -> id_ex_imm=32'hFFFF_FFF8.
- x0 rules: wb_en=1 wb_rd=0 wb_data=7, then read x0 -> id_ex_a=0; lw x0,... followed by use of x0 -> hazard stays 0.
